// File: rtl/ps_pkg.sv
// -----------------------------------------------------------------------------
// ps_pkg
// Shared definitions for the program-sequencer interrupt logic.
//   ic_state_t        : interrupt responder FSM states
//   IVT_ADDR_DEFAULT  : default interrupt vector address (16-bit PMA)
// -----------------------------------------------------------------------------
package ps_pkg;

   // NORMAL  : core running, a pending request may be accepted
   // ACK     : one-cycle vector jump (and wake) pulse
   // SERVICE : handler executing, waiting for RTI
   // RETURN  : one-cycle return jump pulse
   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      ACK     = 2'd1,
      SERVICE = 2'd2,
      RETURN  = 2'd3
   } ic_state_t;

   localparam logic [15:0] IVT_ADDR_DEFAULT = 16'h0008;

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Brings an asynchronous interrupt line into the clk domain and flags its
// rising edge. Reusable for any additional interrupt line.
//
// Ports:
//   clk    in  1  core clock
//   reset  in  1  asynchronous, active-low reset
//   irq    in  1  asynchronous request line
//   rise   out 1  high for one cycle after a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module irq_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic rise
);

   // s1/s2 form the metastability synchroniser; s3 holds the previous
   // synchronised value for edge detection.
   logic s1;
   logic s2;
   logic s3;

   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the pre-edge value of its neighbour; blocking here would collapse
   // the chain into a single flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= irq;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/ps_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// ps_interrupt_ctrl
// Interrupt responder for the program sequencer. Synchronises and edge-detects
// the external request, holds one pending interrupt, redirects fetch to the
// interrupt vector on acceptance (saving the return PC), wakes the sequencer
// out of IDLE, and replays the saved PC when RTI is decoded.
//
// Parameters:
//   PMA_SIZE   program-memory address width
//   IVT_ADDR   interrupt vector address
//   CNT_WIDTH  width of the saturating accepted-interrupt counter
//
// Ports:
//   clk             in   1          core clock
//   reset           in   1          asynchronous, active-low reset
//   interrupt       in   1          external request, async, rising-edge
//   ps_idle         in   1          sequencer is in IDLE
//   ps_irpten       in   1          global interrupt enable
//   ps_stall        in   1          pipeline stalled, fetch cannot redirect
//   ps_pc           in   PMA_SIZE   return address (next instruction)
//   ps_rti          in   1          RTI decoded, one-cycle pulse
//   ic_vector_jump  out  1          pulse: fetch from ic_vector_addr
//   ic_vector_addr  out  PMA_SIZE   constant IVT_ADDR
//   ic_wake         out  1          pulse: leave IDLE (with vector jump)
//   ic_ret_jump     out  1          pulse: fetch from ic_ret_addr
//   ic_ret_addr     out  PMA_SIZE   saved return PC
//   ic_in_service   out  1          handler executing
//   ic_pending      out  1          request latched, not yet accepted
//   ic_overrun      out  1          sticky: a request was lost
//   ic_irq_count    out  CNT_WIDTH  accepted interrupts, saturating
// -----------------------------------------------------------------------------
module ps_interrupt_ctrl
   import ps_pkg::*;
#(
   parameter int                     PMA_SIZE  = 16,
   parameter logic [PMA_SIZE-1:0]    IVT_ADDR  = PMA_SIZE'(IVT_ADDR_DEFAULT),
   parameter int                     CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 interrupt,
   input  logic                 ps_idle,
   input  logic                 ps_irpten,
   input  logic                 ps_stall,
   input  logic [PMA_SIZE-1:0]  ps_pc,
   input  logic                 ps_rti,
   output logic                 ic_vector_jump,
   output logic [PMA_SIZE-1:0]  ic_vector_addr,
   output logic                 ic_wake,
   output logic                 ic_ret_jump,
   output logic [PMA_SIZE-1:0]  ic_ret_addr,
   output logic                 ic_in_service,
   output logic                 ic_pending,
   output logic                 ic_overrun,
   output logic [CNT_WIDTH-1:0] ic_irq_count
);

   // ---------------------------------------------------------------------
   // Request synchroniser and edge detect
   // ---------------------------------------------------------------------
   logic rise;

   irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (interrupt),
      .rise  (rise)
   );

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   ic_state_t state;
   ic_state_t state_nxt;

   logic pending;
   logic accept;

   logic vector_jump_nxt;
   logic wake_nxt;
   logic ret_jump_nxt;
   logic in_service_nxt;

   // Acceptance is only possible from NORMAL; enable and stall are
   // deliberately not looked at in any other state.
   assign accept = (state == NORMAL) & pending & ps_irpten & ~ps_stall;

   // NOTE: every signal written here gets a default before the case so no
   // path leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      state_nxt       = state;
      vector_jump_nxt = 1'b0;
      wake_nxt        = 1'b0;
      ret_jump_nxt    = 1'b0;
      in_service_nxt  = 1'b0;

      case (state)
         NORMAL: begin
            if (accept) begin
               state_nxt = ACK;
            end
         end
         ACK: begin
            state_nxt = SERVICE;
         end
         SERVICE: begin
            if (ps_rti) begin
               state_nxt = RETURN;
            end
         end
         RETURN: begin
            state_nxt = NORMAL;
         end
         default: begin
            state_nxt = NORMAL;
         end
      endcase

      // Moore outputs are decoded from the next state and registered, so the
      // pulses are clean flop outputs aligned with the state they belong to.
      vector_jump_nxt = (state_nxt == ACK);
      wake_nxt        = accept & ps_idle;
      ret_jump_nxt    = (state_nxt == RETURN);
      in_service_nxt  = (state_nxt == SERVICE) | (state_nxt == RETURN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= NORMAL;
         ic_vector_jump <= 1'b0;
         ic_wake        <= 1'b0;
         ic_ret_jump    <= 1'b0;
         ic_in_service  <= 1'b0;
      end else begin
         state          <= state_nxt;
         ic_vector_jump <= vector_jump_nxt;
         ic_wake        <= wake_nxt;
         ic_ret_jump    <= ret_jump_nxt;
         ic_in_service  <= in_service_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Pending latch and overrun flag
   // ---------------------------------------------------------------------
   // A rise on the accept edge wins over the clear: the new request is held
   // rather than being swallowed by the one being accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending    <= 1'b0;
         ic_overrun <= 1'b0;
      end else begin
         if (rise) begin
            pending <= 1'b1;
         end else if (accept) begin
            pending <= 1'b0;
         end

         // Only one request can be held; a second one arriving while the
         // first is still waiting (and not leaving this edge) is lost.
         if (rise & pending & ~accept) begin
            ic_overrun <= 1'b1;
         end
      end
   end

   assign ic_pending = pending;

   // ---------------------------------------------------------------------
   // Return address and accept counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ic_ret_addr  <= '0;
         ic_irq_count <= '0;
      end else if (accept) begin
         ic_ret_addr <= ps_pc;
         if (ic_irq_count != {CNT_WIDTH{1'b1}}) begin
            ic_irq_count <= ic_irq_count + CNT_WIDTH'(1);
         end
      end
   end

   assign ic_vector_addr = IVT_ADDR;

endmodule

// File: tb/tb_ps_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps_interrupt_ctrl
// Self-checking bench: directed scenarios with literal expectations plus
// randomised traffic, all outputs compared every cycle against a behavioural
// model that tracks pulses, handler activity and request bookkeeping.
// -----------------------------------------------------------------------------
module tb_ps_interrupt_ctrl;

   localparam int CW = 4;  // small counter so saturation is reached

   logic          clk = 1'b0;
   logic          reset;
   logic          interrupt;
   logic          ps_idle;
   logic          ps_irpten;
   logic          ps_stall;
   logic [15:0]   ps_pc;
   logic          ps_rti;
   logic          ic_vector_jump;
   logic [15:0]   ic_vector_addr;
   logic          ic_wake;
   logic          ic_ret_jump;
   logic [15:0]   ic_ret_addr;
   logic          ic_in_service;
   logic          ic_pending;
   logic          ic_overrun;
   logic [CW-1:0] ic_irq_count;

   ps_interrupt_ctrl #(
      .PMA_SIZE  (16),
      .IVT_ADDR  (16'h0008),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .interrupt      (interrupt),
      .ps_idle        (ps_idle),
      .ps_irpten      (ps_irpten),
      .ps_stall       (ps_stall),
      .ps_pc          (ps_pc),
      .ps_rti         (ps_rti),
      .ic_vector_jump (ic_vector_jump),
      .ic_vector_addr (ic_vector_addr),
      .ic_wake        (ic_wake),
      .ic_ret_jump    (ic_ret_jump),
      .ic_ret_addr    (ic_ret_addr),
      .ic_in_service  (ic_in_service),
      .ic_pending     (ic_pending),
      .ic_overrun     (ic_overrun),
      .ic_irq_count   (ic_irq_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int dut_jumps = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model
   // Samples of the request pin from the last three edges decide when a new
   // request becomes visible (two edges to synchronise, one to latch). The
   // visible outputs are tracked directly as pulse / activity flags.
   // ---------------------------------------------------------------------
   bit        m_h1, m_h2, m_h3;   // interrupt sampled 1, 2, 3 edges ago
   bit        m_pend;
   bit        m_ovr;
   bit        m_jump;
   bit        m_wake;
   bit        m_handler;          // handler running, RTI not yet seen
   bit        m_ret;              // return pulse
   bit [15:0] m_retaddr;
   int        m_accepts;          // since last reset
   int        m_rises   = 0;      // running totals, never cleared
   int        m_lost    = 0;

   task automatic model_reset();
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
      m_pend = 0; m_ovr = 0; m_jump = 0; m_wake = 0;
      m_handler = 0; m_ret = 0; m_retaddr = '0; m_accepts = 0;
   endtask

   task automatic model_step();
      bit new_req, acc, busy, was_pend, was_jump, was_handler;
      new_req     = m_h2 && !m_h3;
      m_h3        = m_h2;
      m_h2        = m_h1;
      m_h1        = interrupt;
      was_pend    = m_pend;
      was_jump    = m_jump;
      was_handler = m_handler;
      busy        = m_jump || m_handler || m_ret;
      acc         = !busy && m_pend && ps_irpten && !ps_stall;

      m_ret     = was_handler && ps_rti;
      m_handler = (was_handler && !ps_rti) || was_jump;
      m_jump    = acc;
      m_wake    = acc && ps_idle;
      if (acc) begin
         m_retaddr = ps_pc;
         m_accepts++;
      end
      if (new_req) m_rises++;
      if (new_req && was_pend && !acc) begin
         m_ovr = 1;
         m_lost++;
      end
      m_pend = new_req ? 1'b1 : (acc ? 1'b0 : was_pend);
   endtask

   task automatic compare_all();
      int exp_cnt;
      exp_cnt = (m_accepts > (2**CW - 1)) ? (2**CW - 1) : m_accepts;
      if (ic_vector_jump === 1'b1) dut_jumps++;
      check("vector_jump", ic_vector_jump, m_jump);
      check("vector_addr", ic_vector_addr, 16'h0008);
      check("wake",        ic_wake,        m_wake);
      check("ret_jump",    ic_ret_jump,    m_ret);
      check("ret_addr",    ic_ret_addr,    m_retaddr);
      check("in_service",  ic_in_service,  m_handler || m_ret);
      check("pending",     ic_pending,     m_pend);
      check("overrun",     ic_overrun,     m_ovr);
      check("irq_count",   ic_irq_count,   exp_cnt);
   endtask

   // One clock: model follows the edge, outputs compared at the falling edge.
   // Inputs are changed by the caller right after this returns.
   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      else       model_reset();
      @(negedge clk);
      cyc++;
      if (reset) compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Request high for exactly one sampling edge (that edge is E).
   task automatic pulse_irq();
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
   endtask

   task automatic do_rti();
      ps_rti = 1'b1;
      tick();
      ps_rti = 1'b0;
      tick();
   endtask

   int base_jumps, base_rises, base_lost, exp_acc;

   initial begin
      reset     = 1'b0;
      interrupt = 1'b0;
      ps_idle   = 1'b0;
      ps_irpten = 1'b0;
      ps_stall  = 1'b0;
      ps_pc     = '0;
      ps_rti    = 1'b0;
      model_reset();

      // ---------------- reset state ----------------
      ticks(3);
      check("rst_vector_jump", ic_vector_jump, 1'b0);
      check("rst_vector_addr", ic_vector_addr, 16'h0008);
      check("rst_in_service",  ic_in_service,  1'b0);
      check("rst_pending",     ic_pending,     1'b0);
      check("rst_count",       ic_irq_count,   0);
      reset = 1'b1;
      ticks(2);

      // ---------------- single request, core running ----------------
      ps_irpten = 1'b1;
      ps_pc     = 16'h0123;
      pulse_irq();                                  // edge E
      ticks(2);                                     // E+1, E+2
      check("d1_pending_at_E+2", ic_pending, 1'b1);
      check("d1_no_jump_yet",    ic_vector_jump, 1'b0);
      tick();                                       // E+3
      check("d1_jump_at_E+3", ic_vector_jump, 1'b1);
      check("d1_ret_addr",    ic_ret_addr,    16'h0123);
      check("d1_count",       ic_irq_count,   1);
      check("d1_no_wake",     ic_wake,        1'b0);
      ps_pc = 16'h0456;
      tick();
      check("d1_jump_one_cycle", ic_vector_jump, 1'b0);
      check("d1_in_service",     ic_in_service,  1'b1);
      ticks(3);
      ps_rti = 1'b1;
      tick();                                       // edge R
      ps_rti = 1'b0;
      check("d1_ret_jump",      ic_ret_jump, 1'b1);
      check("d1_ret_addr_kept", ic_ret_addr, 16'h0123);
      tick();
      check("d1_ret_one_cycle", ic_ret_jump,   1'b0);
      check("d1_back_normal",   ic_in_service, 1'b0);

      // ---------------- request during IDLE ----------------
      ps_idle = 1'b1;
      pulse_irq();
      ticks(3);
      check("d2_jump", ic_vector_jump, 1'b1);
      check("d2_wake", ic_wake,        1'b1);
      ps_idle = 1'b0;
      tick();
      check("d2_wake_one_cycle", ic_wake, 1'b0);
      do_rti();

      // ---------------- stall for 4 cycles ----------------
      pulse_irq();
      ticks(2);
      ps_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("d3_stalled_no_jump", ic_vector_jump, 1'b0);
      end
      ps_stall = 1'b0;
      tick();                                       // E+7
      check("d3_jump_after_stall", ic_vector_jump, 1'b1);
      tick();
      do_rti();

      // ---------------- masked request ----------------
      ps_irpten = 1'b0;
      pulse_irq();
      ticks(10);
      check("d4_masked_pending", ic_pending,     1'b1);
      check("d4_masked_no_jump", ic_vector_jump, 1'b0);
      ps_irpten = 1'b1;
      tick();
      check("d4_jump_on_enable", ic_vector_jump, 1'b1);
      check("d4_count",          ic_irq_count,   4);
      tick();
      do_rti();

      // ---------------- requests during SERVICE ----------------
      pulse_irq();
      ticks(4);
      check("d5_in_service", ic_in_service, 1'b1);
      pulse_irq();
      ticks(2);
      check("d5_pending", ic_pending, 1'b1);
      check("d5_no_ovr",  ic_overrun, 1'b0);
      pulse_irq();
      ticks(2);
      check("d5_overrun", ic_overrun, 1'b1);
      base_jumps = dut_jumps;
      do_rti();
      ticks(8);
      check("d5_one_more_accept", dut_jumps - base_jumps, 1);
      check("d5_count",           ic_irq_count,           6);
      do_rti();

      // ---------------- spurious RTI in NORMAL ----------------
      ps_rti = 1'b1;
      tick();
      ps_rti = 1'b0;
      check("d6_no_ret_jump", ic_ret_jump,   1'b0);
      check("d6_no_service",  ic_in_service, 1'b0);
      tick();

      // ---------------- reset mid-SERVICE ----------------
      pulse_irq();
      ticks(4);
      check("d7_in_service", ic_in_service, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("d7_rst_in_service", ic_in_service, 1'b0);
      check("d7_rst_ret_addr",   ic_ret_addr,   16'h0000);
      check("d7_rst_count",      ic_irq_count,  0);
      check("d7_rst_overrun",    ic_overrun,    1'b0);
      check("d7_rst_pending",    ic_pending,    1'b0);
      check("d7_rst_ret_jump",   ic_ret_jump,   1'b0);
      check("d7_rst_vector_addr", ic_vector_addr, 16'h0008);
      tick();
      reset = 1'b1;
      ticks(2);

      // ---------------- random bursts: enabled, no stalls ----------------
      base_jumps = dut_jumps;
      base_rises = m_rises;
      base_lost  = m_lost;
      for (int i = 0; i < 1500; i++) begin
         interrupt = ($urandom_range(0, 2) == 0);
         ps_idle   = $urandom_range(0, 1);
         ps_rti    = ($urandom_range(0, 3) == 0);
         ps_pc     = 16'($urandom);
         tick();
      end
      interrupt = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ps_rti = ~ps_rti;
         tick();
      end
      ps_rti = 1'b0;
      ticks(2);
      check("r1_drained_pending", ic_pending, 1'b0);
      exp_acc = (m_rises - base_rises) - (m_lost - base_lost);
      check("r1_accepts_vs_edges", dut_jumps - base_jumps, exp_acc);

      // ---------------- random everything ----------------
      for (int i = 0; i < 1500; i++) begin
         interrupt = ($urandom_range(0, 3) == 0);
         ps_idle   = $urandom_range(0, 1);
         ps_irpten = ($urandom_range(0, 3) != 0);
         ps_stall  = ($urandom_range(0, 2) == 0);
         ps_rti    = ($urandom_range(0, 4) == 0);
         ps_pc     = 16'($urandom);
         tick();
      end
      interrupt = 1'b0;
      ps_stall  = 1'b0;
      ps_rti    = 1'b0;
      ticks(2);
      check("r2_count_saturated", ic_irq_count, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps_interrupt_ctrl.md
# ps_interrupt_ctrl

Interrupt responder for the program sequencer inside `core_top`. It sits between the external `interrupt` pin and the sequencer's fetch logic. It synchronises and edge-detects the request, holds one pending interrupt, and redirects fetch to the interrupt vector when the request is accepted, saving the return PC at the same time. It also wakes the sequencer out of IDLE, and replays the saved PC when the sequencer decodes RTI.

## Interface
Parameters:
- `PMA_SIZE`, 16: program-memory address width.
- `IVT_ADDR`, 16'h0008: interrupt vector address; width `PMA_SIZE`.
- `CNT_WIDTH`, 8: width of the accepted-interrupt counter.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `interrupt`  in  1  external request; asynchronous; rising-edge sensitive; minimum high time 1 cycle.
- `ps_idle`  in  1  sequencer is in IDLE.
- `ps_irpten`  in  1  global interrupt enable.
- `ps_stall`  in  1  pipeline stalled; fetch cannot be redirected this cycle.
- `ps_pc`  in  PMA_SIZE  address of the next instruction to execute (the return address).
- `ps_rti`  in  1  RTI decoded; one-cycle pulse.
- `ic_vector_jump`  out  1  one-cycle pulse: fetch from `ic_vector_addr`.
- `ic_vector_addr`  out  PMA_SIZE  constant `IVT_ADDR`.
- `ic_wake`  out  1  one-cycle pulse: leave IDLE. Coincides with `ic_vector_jump`.
- `ic_ret_jump`  out  1  one-cycle pulse: fetch from `ic_ret_addr`.
- `ic_ret_addr`  out  PMA_SIZE  saved return PC.
- `ic_in_service`  out  1  handler is executing.
- `ic_pending`  out  1  request latched and not yet accepted.
- `ic_overrun`  out  1  sticky flag: a request was lost.
- `ic_irq_count`  out  CNT_WIDTH  number of accepted interrupts; saturates.

## Operation
- Reset (`reset`=0, asynchronous) clears all flops and all outputs to 0 and puts the FSM in NORMAL. `ic_vector_addr` is `IVT_ADDR` at all times.
- Synchroniser: two flops (`s1`, `s2`) followed by a delay flop `s3`. The edge condition is `rise` = `s2` & !`s3`.
- Pending latch:
  - Set on `rise`.
  - Cleared on the edge where the request is accepted.
  - If `rise` and acceptance occur on the same edge, pending stays set; the new request is held.
  - `rise` while pending is already set, and not on an accept edge, sets `ic_overrun`.
- FSM states, all with registered (Moore) outputs:
  - NORMAL → ACK when pending & `ps_irpten` & !`ps_stall`. On that edge: `ic_ret_addr` <= `ps_pc`, pending cleared, `ic_irq_count` += 1 (saturating at all-ones).
  - ACK (one cycle): `ic_vector_jump`=1. `ic_wake`=1 if `ps_idle` was 1 on the accept edge. Next state is SERVICE.
  - SERVICE: `ic_in_service`=1. New requests set pending but are not accepted; there is no nesting. `ps_rti` → RETURN.
  - RETURN (one cycle): `ic_ret_jump`=1 and `ic_in_service`=1. Next state is NORMAL. A pending request can be accepted from NORMAL one cycle later.
- `ps_rti` is ignored outside SERVICE.
- `ps_stall` and `ps_irpten` are ignored in ACK, SERVICE and RETURN.
- With `ps_irpten`=0, a request stays pending indefinitely and is accepted as soon as enable returns.
- `ic_pending` shows the latch directly.

## Timing
- Let E be the first posedge that samples `interrupt`=1 after it was 0.
  - `s1`=1 after E, `s2`=1 after E+1, pending=1 after E+2.
  - Earliest accept edge is E+3, so `ic_vector_jump` is high from E+3 to E+4.
  - Interrupt latency is therefore 3 cycles from the sampling edge to the jump pulse.
- Stall: each cycle with `ps_stall`=1 in NORMAL delays acceptance by one cycle.
- RTI: `ps_rti` sampled at edge R in SERVICE gives `ic_ret_jump` high from R to R+1, and NORMAL from R+1.
- Reset mid-ACK, mid-SERVICE or mid-RETURN: the pulse drops immediately (asynchronous). The saved PC and pending latch are lost; no RTI replay occurs.

## Structure
- Shared package `ps_pkg`:
  - FSM state enum `ic_state_t` {NORMAL, ACK, SERVICE, RETURN}.
  - Default `IVT_ADDR` constant.
- Sub-module `irq_sync_edge`: the two-flop synchroniser plus edge detect, with output `rise`. It is reusable for future interrupt lines.
- The top level holds the pending latch, FSM, return register and counter.

## Test plan
- Single request, core running: raise `interrupt` at E with `ps_pc`=16'h0123 and `ps_irpten`=1 → `ic_vector_jump` high from E+3 to E+4, `ic_ret_addr`=16'h0123, `ic_irq_count`=1. A later `ps_rti` → one `ic_ret_jump` pulse carrying 16'h0123.
- Request during IDLE: `ps_idle`=1 → `ic_wake` and `ic_vector_jump` are asserted together, both one cycle.
- Stall and mask:
  - `ps_stall`=1 for 4 cycles after pending sets → jump delayed exactly 4 cycles.
  - `ps_irpten`=0 → `ic_pending` stays 1 and no jump occurs until enable returns.
- Request during SERVICE, then another before RTI:
  - First extra request → pending=1.
  - Second → `ic_overrun`=1.
  - After RTI → exactly one further accept; count increments by one only.
- Spurious `ps_rti` in NORMAL → no `ic_ret_jump`. Reset asserted mid-SERVICE → all outputs 0 and FSM in NORMAL. Randomised request bursts while idle (`ps_irpten`=1, no stalls) → accepts equal the sum of rising edges minus overruns.
